// File: rtl/triangle_rasterizer_pkg.sv
// Shared geometry types, screen defaults and FSM encoding for the triangle rasterizer.
// Coordinates are signed 16-bit; vertices may lie anywhere, fragments never leave the screen.
package triangle_rasterizer_pkg;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    typedef struct packed {
        shortint x;
        shortint y;
    } point2d_t;

    typedef struct packed {
        shortint x;
        shortint y;
        shortint z;
    } point3d_t;

    typedef struct packed {
        point3d_t p;
        point3d_t q;
        point3d_t r;
    } triangle3d_t;

    typedef struct packed {
        shortint xmin;
        shortint xmax;
        shortint ymin;
        shortint ymax;
    } bbox_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SCAN   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    function automatic shortint min3(input shortint a, input shortint b, input shortint c);
        shortint m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic shortint max3(input shortint a, input shortint b, input shortint c);
        shortint m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic point2d_t to_2d(input point3d_t v);
        point2d_t o;
        o.x = v.x;
        o.y = v.y;
        return o;
    endfunction

endpackage

// File: rtl/triangle_rasterizer_if.sv
// Triangle-in / fragment-out stream bundle of the rasterizer.
// Both channels: a beat transfers on a rising clk with valid && ready; valid holds with stable data until ready.
interface triangle_rasterizer_if;
    import triangle_rasterizer_pkg::*;

    logic        tri_valid;
    logic        tri_ready;
    triangle3d_t triangle;
    logic        frag_valid;
    logic        frag_ready;
    point2d_t    frag_point;
    triangle3d_t frag_triangle;

    modport slave (
        input  tri_valid,
        input  triangle,
        input  frag_ready,
        output tri_ready,
        output frag_valid,
        output frag_point,
        output frag_triangle
    );

    modport master (
        output tri_valid,
        output triangle,
        output frag_ready,
        input  tri_ready,
        input  frag_valid,
        input  frag_point,
        input  frag_triangle
    );

endinterface

// File: rtl/triangle_rasterizer_edge_function.sv
// Combinational edge function E(a,b,pt) = (b.x-a.x)*(pt.y-a.y) - (b.y-a.y)*(pt.x-a.x).
// 17-bit differences and 34-bit products keep the full 16-bit coordinate range exact.
module edge_function
    import triangle_rasterizer_pkg::*;
(
    input  point2d_t           a,
    input  point2d_t           b,
    input  point2d_t           pt,
    output logic signed [34:0] w
);

    logic signed [16:0] bax;
    logic signed [16:0] bay;
    logic signed [16:0] pax;
    logic signed [16:0] pay;
    logic signed [33:0] m0;
    logic signed [33:0] m1;

    assign bax = 17'(b.x) - 17'(a.x);
    assign bay = 17'(b.y) - 17'(a.y);
    assign pax = 17'(pt.x) - 17'(a.x);
    assign pay = 17'(pt.y) - 17'(a.y);

    assign m0 = 34'(bax) * 34'(pay);
    assign m1 = 34'(bay) * 34'(pax);
    assign w  = 35'(m0) - 35'(m1);

endmodule

// File: rtl/triangle_rasterizer.sv
// Scans the screen-clipped bounding box of one triangle in row-major order and streams
// every covered pixel, paired with the held triangle, through a one-entry output register.
module triangle_rasterizer
    import triangle_rasterizer_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic                 clk,
    input  logic                 n_rst,
    triangle_rasterizer_if.slave rif,
    output logic                 busy,
    output logic                 done,
    output state_t               dbg_state
);

    localparam shortint X_LAST = shortint'(SCREEN_W - 1);
    localparam shortint Y_LAST = shortint'(SCREEN_H - 1);

    state_t      state_q, state_d;
    triangle3d_t tri_q, tri_d;
    bbox_t       bbox_q, bbox_d;
    shortint     cx_q, cx_d;
    shortint     cy_q, cy_d;
    logic        frag_valid_q, frag_valid_d;
    point2d_t    frag_point_q, frag_point_d;

    point2d_t           vp, vq, vr, cand;
    logic signed [34:0] w0, w1, w2, area2;
    shortint            xmin_c, xmax_c, ymin_c, ymax_c;
    logic               bbox_empty;
    logic               covered;
    logic               stall;

    assign vp      = to_2d(tri_q.p);
    assign vq      = to_2d(tri_q.q);
    assign vr      = to_2d(tri_q.r);
    assign cand    = {cx_q, cy_q};

    edge_function u_w0   (.a(vq), .b(vr), .pt(cand), .w(w0));
    edge_function u_w1   (.a(vr), .b(vp), .pt(cand), .w(w1));
    edge_function u_w2   (.a(vp), .b(vq), .pt(cand), .w(w2));
    edge_function u_area (.a(vp), .b(vq), .pt(vr),   .w(area2));

    // Clipping only pulls each bound inward, so a box fully off one side ends up empty.
    always_comb begin
        xmin_c = min3(vp.x, vq.x, vr.x);
        xmax_c = max3(vp.x, vq.x, vr.x);
        ymin_c = min3(vp.y, vq.y, vr.y);
        ymax_c = max3(vp.y, vq.y, vr.y);
        if (xmin_c < 16'sd0)  xmin_c = 16'sd0;
        if (xmax_c > X_LAST)  xmax_c = X_LAST;
        if (ymin_c < 16'sd0)  ymin_c = 16'sd0;
        if (ymax_c > Y_LAST)  ymax_c = Y_LAST;
        bbox_empty = (xmin_c > xmax_c) || (ymin_c > ymax_c);
    end

    assign covered = ((w0 >= 35'sd0) && (w1 >= 35'sd0) && (w2 >= 35'sd0)) ||
                     ((w0 <= 35'sd0) && (w1 <= 35'sd0) && (w2 <= 35'sd0));
    assign stall   = frag_valid_q && !rif.frag_ready;

    always_comb begin
        state_d      = state_q;
        tri_d        = tri_q;
        bbox_d       = bbox_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        // An accepted fragment frees the register; a new load below may refill it in the same cycle.
        frag_valid_d = frag_valid_q && !rif.frag_ready;
        frag_point_d = frag_point_q;

        case (state_q)
            ST_IDLE: begin
                if (rif.tri_valid) begin
                    tri_d   = rif.triangle;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                bbox_d.xmin = xmin_c;
                bbox_d.xmax = xmax_c;
                bbox_d.ymin = ymin_c;
                bbox_d.ymax = ymax_c;
                if (bbox_empty || (area2 == 35'sd0)) begin
                    state_d = ST_FINISH;
                end else begin
                    cx_d    = xmin_c;
                    cy_d    = ymin_c;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!stall) begin
                    if (covered) begin
                        frag_valid_d = 1'b1;
                        frag_point_d = cand;
                    end
                    if (cx_q == bbox_q.xmax) begin
                        if (cy_q == bbox_q.ymax) begin
                            state_d = ST_DRAIN;
                        end else begin
                            cx_d = bbox_q.xmin;
                            cy_d = cy_q + 16'sd1;
                        end
                    end else begin
                        cx_d = cx_q + 16'sd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!frag_valid_q || rif.frag_ready) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            tri_q        <= '0;
            bbox_q       <= '0;
            cx_q         <= 16'sd0;
            cy_q         <= 16'sd0;
            frag_valid_q <= 1'b0;
            frag_point_q <= '0;
        end else begin
            state_q      <= state_d;
            tri_q        <= tri_d;
            bbox_q       <= bbox_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            frag_valid_q <= frag_valid_d;
            frag_point_q <= frag_point_d;
        end
    end

    assign rif.tri_ready     = (state_q == ST_IDLE);
    assign rif.frag_valid    = frag_valid_q;
    assign rif.frag_point    = frag_point_q;
    assign rif.frag_triangle = tri_q;
    assign busy              = (state_q != ST_IDLE);
    assign done              = (state_q == ST_FINISH);
    assign dbg_state         = state_q;

endmodule
